// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM encodings, default line settings,
// bit-period and clog2 helpers. Parity state exists only with UART_TX_PARITY_EN.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ = 65_000_000;
  localparam int unsigned DEF_BAUD     = 115_200;

  localparam int unsigned STATE_W = 5;
  localparam logic [STATE_W-1:0] ST_IDLE   = 5'b00001;
  localparam logic [STATE_W-1:0] ST_START  = 5'b00010;
  localparam logic [STATE_W-1:0] ST_DATA   = 5'b00100;
`ifdef UART_TX_PARITY_EN
  localparam logic [STATE_W-1:0] ST_PARITY = 5'b01000;
`endif
  localparam logic [STATE_W-1:0] ST_STOP   = 5'b10000;

  // Bit period in clocks, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32'd32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered full/empty/count; a push while full is
// accepted only when a pop happens in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  input  logic                   push,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout_c,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [CW-1:0]    count_nxt;

  always_comb begin
    pop_ok    = pop & ~empty;
    push_ok   = push & (~full | pop_ok);
    count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  end

  assign dout_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO absorbs byte bursts, FSM sends 8N1 frames
// back-to-back (8E1 when UART_TX_PARITY_EN is defined).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned FIFO_DEPTH = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  din,
  input  logic                        wr,
  output logic                        tx,
  output logic                        busy,
  output logic                        full,
  output logic                        overflow,
  output logic [clog2(FIFO_DEPTH):0]  count
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned BW  = clog2(DIV);
  localparam int unsigned CW  = clog2(FIFO_DEPTH) + 1;

  logic [STATE_W-1:0] state, state_nxt;
  logic [BW-1:0]      baud_cnt, baud_nxt;
  logic [2:0]         bit_cnt, bit_nxt;
  logic [7:0]         shift, shift_nxt;
  logic               tx_nxt;
  logic               busy_nxt;
  logic               overflow_nxt;
  logic               push;
  logic               pop;
  logic               baud_last;
  logic               fifo_empty;
  logic [7:0]         fifo_dout;
`ifdef UART_TX_PARITY_EN
  logic               parity, parity_nxt;
`endif

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .push   (push),
    .pop    (pop),
    .dout_c (fifo_dout),
    .full   (full),
    .empty  (fifo_empty),
    .count  (count)
  );

  assign baud_last = (baud_cnt == BW'(DIV - 1));

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      tx       <= tx_nxt;
      busy     <= busy_nxt;
      overflow <= overflow_nxt;
`ifdef UART_TX_PARITY_EN
      parity   <= parity_nxt;
`endif
    end
  end

  // Next-state, shift and line logic; a pop at end of stop chains frames with no gap.
  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt + BW'(1);
    bit_nxt    = bit_cnt;
    shift_nxt  = shift;
    tx_nxt     = tx;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_nxt = parity;
`endif

    case (state)
      ST_IDLE: begin
        baud_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_dout;
          tx_nxt    = 1'b0;
          state_nxt = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_nxt = ^fifo_dout;
`endif
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          tx_nxt    = shift[0];
          shift_nxt = {1'b0, shift[7:1]};
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_nxt = '0;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_nxt    = parity;
            state_nxt = ST_PARITY;
`else
            tx_nxt    = 1'b1;
            state_nxt = ST_STOP;
`endif
          end else begin
            bit_nxt   = bit_cnt + 3'd1;
            tx_nxt    = shift[0];
            shift_nxt = {1'b0, shift[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last) begin
          baud_nxt  = '0;
          tx_nxt    = 1'b1;
          state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (baud_last) begin
          baud_nxt = '0;
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = fifo_dout;
            tx_nxt    = 1'b0;
            state_nxt = ST_START;
`ifdef UART_TX_PARITY_EN
            parity_nxt = ^fifo_dout;
`endif
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        baud_nxt  = '0;
        tx_nxt    = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase

    push         = wr & (~full | pop);
    overflow_nxt = overflow | (wr & ~push);
    busy_nxt     = (state_nxt != ST_IDLE) | push | (count > CW'(pop));
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: line monitors decode frames against a byte
// scoreboard; three instances cover default timing, a fast line and a tiny FIFO.
module tb_uart_tx_buffered;

  localparam int DIV_A = 65_000_000 / 115_200;  // 564
  localparam int DIV_F = 6_500_000 / 115_200;   // 56
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct packed {
    logic [1:0] s;
    logic [7:0] b;
  } sb_t;

  logic       clk;
  logic       rst;
  logic [7:0] din  [3];
  logic       wr   [3];
  logic       tx   [3];
  logic       busy [3];
  logic       full [3];
  logic       ovf  [3];
  logic [8:0] count_a;
  logic [8:0] count_b;
  logic [2:0] count_c;

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  bit  skip   = 0;
  sb_t sb[$];
  int  starts[$];

  uart_tx_buffered u_a (
    .clk(clk), .rst(rst), .din(din[0]), .wr(wr[0]), .tx(tx[0]), .busy(busy[0]),
    .full(full[0]), .overflow(ovf[0]), .count(count_a)
  );

  uart_tx_buffered #(.CLK_FREQ(6_500_000), .BAUD(115_200), .FIFO_DEPTH(256)) u_b (
    .clk(clk), .rst(rst), .din(din[1]), .wr(wr[1]), .tx(tx[1]), .busy(busy[1]),
    .full(full[1]), .overflow(ovf[1]), .count(count_b)
  );

  uart_tx_buffered #(.CLK_FREQ(6_500_000), .BAUD(115_200), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst), .din(din[2]), .wr(wr[2]), .tx(tx[2]), .busy(busy[2]),
    .full(full[2]), .overflow(ovf[2]), .count(count_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int div_of(input int s);
    return (s == 0) ? DIV_A : DIV_F;
  endfunction

  // Decode frames on one line, sampling mid-bit, and compare with the scoreboard.
  task automatic monitor(input int s);
    logic [7:0] d;
    logic       st;
    logic       sp;
    logic [8:0] expd;
    sb_t        e;
    int         nd;
`ifdef UART_TX_PARITY_EN
    logic       par;
`endif
    nd = div_of(s);
    forever begin
      @(negedge clk);
      if (tx[s] === 1'b0) begin
        starts.push_back(cyc);
        repeat (nd / 2) @(negedge clk);
        st = tx[s];
        for (int i = 0; i < 8; i++) begin
          repeat (nd) @(negedge clk);
          d[i] = tx[s];
        end
`ifdef UART_TX_PARITY_EN
        repeat (nd) @(negedge clk);
        par = tx[s];
`endif
        repeat (nd) @(negedge clk);
        sp = tx[s];
        if (skip) begin
          skip = 1'b0;
        end else begin
          expd = 9'h100;
          if (sb.size() != 0) begin
            e = sb.pop_front();
            if (int'(e.s) == s) expd = {1'b0, e.b};
          end
          check("frame_start", st, 1'b0);
          check("frame_data", {23'd0, 1'b0, d}, {23'd0, expd});
          check("frame_stop", sp, 1'b1);
`ifdef UART_TX_PARITY_EN
          check("frame_parity", par, ^expd[7:0]);
`endif
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  // Drive one write strobe at a negedge; returns at the following negedge.
  task automatic send(input int s, input logic [7:0] b, input bit accepted);
    din[s] = b;
    wr[s]  = 1'b1;
    if (accepted) sb.push_back('{s: 2'(s), b: b});
    @(negedge clk);
    wr[s] = 1'b0;
  endtask

  task automatic wait_idle(input int s, input int budget, output int at);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy[s] !== 1'b0 && n < budget);
    check("idle_timeout", busy[s], 1'b0);
    at = cyc;
  endtask

  initial begin
    int c0;
    int at;
    int unsigned expc [6] = '{1, 1, 2, 3, 4, 4};

    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      din[s] = 8'h00;
      wr[s]  = 1'b0;
    end

    // Test 1: reset state
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("rst_tx", tx[s], 1'b1);
      check("rst_busy", busy[s], 1'b0);
      check("rst_full", full[s], 1'b0);
      check("rst_overflow", ovf[s], 1'b0);
    end
    check("rst_count_a", count_a, 0);
    check("rst_count_b", count_b, 0);
    check("rst_count_c", count_c, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Test 2: single byte at 564 clocks per bit; busy spans the FIFO cycle plus the frame
    send(0, 8'h56, 1'b1);
    c0 = cyc;
    check("t2_count_after_wr", count_a, 1);
    check("t2_busy_after_wr", busy[0], 1'b1);
    check("t2_no_bypass", tx[0], 1'b1);
    @(negedge clk);
    check("t2_start_low", tx[0], 1'b0);
    check("t2_count_popped", count_a, 0);
    wait_idle(0, 20 * DIV_A, at);
    check("t2_busy_len", at - c0, NBITS * DIV_A + 1);
    check("t2_drained", sb.size(), 0);

    // Test 3: 14 bytes, write every 2nd cycle, frames must be back-to-back
    starts.delete();
    for (int i = 0; i < 14; i++) begin
      send(1, 8'($urandom_range(0, 255)), 1'b1);
      @(negedge clk);
    end
    wait_idle(1, 20 * 14 * DIV_F, at);
    check("t3_frames", starts.size(), 14);
    if (starts.size() == 14) begin
      for (int i = 1; i < 14; i++)
        check("t3_gap", starts[i] - starts[i-1], NBITS * DIV_F);
      check("t3_total", at - starts[0], 14 * NBITS * DIV_F);
    end
    check("t3_overflow", ovf[1], 1'b0);
    check("t3_drained", sb.size(), 0);

    // Test 4: depth-4 FIFO, 6 consecutive writes, the 6th is dropped
    for (int i = 0; i < 6; i++) begin
      send(2, 8'hC0 + 8'(i), i < 5);
      check("t4_count", count_c, expc[i]);
      check("t4_full", full[2], i >= 4);
      check("t4_overflow", ovf[2], i == 5);
    end
    wait_idle(2, 10 * NBITS * DIV_F, at);
    check("t4_overflow_sticky", ovf[2], 1'b1);
    check("t4_full_after", full[2], 1'b0);
    check("t4_drained", sb.size(), 0);

    // Test 5: reset in the middle of data bit 3, then a clean frame
    send(1, 8'hA5, 1'b1);
    repeat (1 + 4 * DIV_F + DIV_F / 2) @(negedge clk);
    check("t5_in_bit3", tx[1], 1'b0);
    rst = 1'b1;
    sb.delete();
    skip = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_tx", tx[1], 1'b1);
    check("t5_rst_count", count_b, 0);
    check("t5_rst_busy", busy[1], 1'b0);
    repeat (7 * DIV_F) @(negedge clk);
    send(1, 8'h3C, 1'b1);
    c0 = cyc;
    wait_idle(1, 20 * DIV_F, at);
    check("t5_busy_len", at - c0, NBITS * DIV_F + 1);
    check("t5_drained", sb.size(), 0);

`ifdef UART_TX_PARITY_EN
    // Test 6: 8E1 frame of 0x31 (parity 1) at 564 clocks per bit
    send(0, 8'h31, 1'b1);
    c0 = cyc;
    wait_idle(0, 20 * DIV_A, at);
    check("t6_busy_len", at - c0, 11 * DIV_A + 1);
    check("t6_drained", sb.size(), 0);
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
